// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: CPU opcode/funct encodings and mult/div latencies shared by the hazard logic.
package hazard_ctrl_pkg;
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1A;
   localparam logic [5:0] FN_DIVU    = 6'h1B;
   localparam logic [5:0] MD_LAT_MULT = 6'd5;
   localparam logic [5:0] MD_LAT_DIV  = 6'd32;

   function automatic logic isMdIssue(input logic [5:0] opcode, input logic [5:0] funct);
      return opcode == OP_SPECIAL &&
             (funct == FN_MULT || funct == FN_MULTU || funct == FN_DIV || funct == FN_DIVU);
   endfunction
endpackage

// File: rtl/hazard_ctrl_md_tracker.sv
// md_tracker: counts down the latency of an in-flight mult/div and reports busy.
module md_tracker
   import hazard_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic isDiv,
   output logic mdBusy
);
   logic [5:0] count;

   // A new op is accepted only once the previous one has fully drained.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         count <= '0;
      else
         count <= (count != '0) ? count - 6'd1 :
                  start         ? (isDiv ? MD_LAT_DIV : MD_LAT_MULT) : '0;

   assign mdBusy = count != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush decisions for load-use, branch operand and mult/div hazards.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  Opcode_IFID,
   input  logic [5:0]  Funct_IFID,
   input  logic [4:0]  RsAddr_IFID,
   input  logic [4:0]  RtAddr_IFID,
   input  logic        MemRead_IDEX,
   input  logic        RegWrite_IDEX,
   input  logic [4:0]  RdAddr_IDEX,
   input  logic        MemRead_EXMEM,
   input  logic [4:0]  RdAddr_EXMEM,
   input  logic        BranchTaken_ID,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IDEXFlush,
   output logic        IFIDFlush,
   output logic        MdBusy,
   output logic [15:0] StallCount
);
   logic isBr2, isBr1, mdIssue, mdRead, isDiv;
   logic loadUse, brAlu, brLoad, mdStall, stall;

   assign isBr2   = Opcode_IFID == OP_BEQ || Opcode_IFID == OP_BNE;
   assign isBr1   = Opcode_IFID == OP_REGIMM || Opcode_IFID == OP_BLEZ || Opcode_IFID == OP_BGTZ;
   assign mdIssue = isMdIssue(Opcode_IFID, Funct_IFID);
   assign mdRead  = Opcode_IFID == OP_SPECIAL && (Funct_IFID == FN_MFHI || Funct_IFID == FN_MFLO);
   assign isDiv   = Funct_IFID == FN_DIV || Funct_IFID == FN_DIVU;

   // Register 0 is hardwired, so a zero destination never creates a dependency.
   assign loadUse = MemRead_IDEX && RdAddr_IDEX != '0 &&
                    (RdAddr_IDEX == RsAddr_IFID || RdAddr_IDEX == RtAddr_IFID);
   assign brAlu   = RegWrite_IDEX && RdAddr_IDEX != '0 &&
                    (((isBr2 || isBr1) && RdAddr_IDEX == RsAddr_IFID) || (isBr2 && RdAddr_IDEX == RtAddr_IFID));
   assign brLoad  = MemRead_EXMEM && RdAddr_EXMEM != '0 &&
                    (((isBr2 || isBr1) && RdAddr_EXMEM == RsAddr_IFID) || (isBr2 && RdAddr_EXMEM == RtAddr_IFID));
   assign mdStall = MdBusy && (mdIssue || mdRead);
   assign stall   = loadUse || brAlu || brLoad || mdStall;

   assign PCWrite   = !stall;
   assign IFIDWrite = !stall;
   assign IDEXFlush = stall;
   assign IFIDFlush = BranchTaken_ID && !stall;

   md_tracker u_md (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mdIssue && !stall),
      .isDiv  (isDiv),
      .mdBusy (MdBusy)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         StallCount <= '0;
      else if (stall && StallCount != 16'hFFFF)
         StallCount <= StallCount + 16'd1;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = '0, funct = '0;
   logic [4:0]  rs = '0, rt = '0, rdIdex = '0, rdExmem = '0;
   logic        memReadIdex = 1'b0, regWriteIdex = 1'b0, memReadExmem = 1'b0, brTaken = 1'b0;
   logic        pcWrite, ifidWrite, idexFlush, ifidFlush, mdBusy;
   logic [15:0] stallCount;

   int tests = 0, fails = 0;
   int mdLeft = 0;
   int stallCnt = 0;

   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .Opcode_IFID(opcode), .Funct_IFID(funct),
      .RsAddr_IFID(rs), .RtAddr_IFID(rt),
      .MemRead_IDEX(memReadIdex), .RegWrite_IDEX(regWriteIdex), .RdAddr_IDEX(rdIdex),
      .MemRead_EXMEM(memReadExmem), .RdAddr_EXMEM(rdExmem),
      .BranchTaken_ID(brTaken),
      .PCWrite(pcWrite), .IFIDWrite(ifidWrite), .IDEXFlush(idexFlush), .IFIDFlush(ifidFlush),
      .MdBusy(mdBusy), .StallCount(stallCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit isMul();
      return opcode == 6'h00 && (funct == 6'h18 || funct == 6'h19);
   endfunction

   function automatic bit isDivOp();
      return opcode == 6'h00 && (funct == 6'h1A || funct == 6'h1B);
   endfunction

   // A source register depends on a producer when it is nonzero and named by it.
   function automatic bit dep(input logic [4:0] src, input logic [4:0] dst);
      return src != 0 && src == dst;
   endfunction

   function automatic bit modelStall();
      bit two = opcode == 6'h04 || opcode == 6'h05;
      bit one = opcode == 6'h01 || opcode == 6'h06 || opcode == 6'h07;
      bit rd  = opcode == 6'h00 && (funct == 6'h10 || funct == 6'h12);
      bit s = 0;
      if (memReadIdex && (dep(rs, rdIdex) || dep(rt, rdIdex))) s = 1;
      if (regWriteIdex && (((two || one) && dep(rs, rdIdex)) || (two && dep(rt, rdIdex)))) s = 1;
      if (memReadExmem && (((two || one) && dep(rs, rdExmem)) || (two && dep(rt, rdExmem)))) s = 1;
      if (mdLeft > 0 && (isMul() || isDivOp() || rd)) s = 1;
      return s;
   endfunction

   // Check every output against the model, then take one clock edge and advance the model.
   task automatic step(input string tag);
      bit s;
      #1;
      s = modelStall();
      check({tag, ".pc"}, pcWrite, !s);
      check({tag, ".ifid"}, ifidWrite, !s);
      check({tag, ".idex"}, idexFlush, s);
      check({tag, ".iflush"}, ifidFlush, brTaken && !s);
      check({tag, ".busy"}, mdBusy, mdLeft > 0);
      check({tag, ".cnt"}, stallCount, stallCnt);
      @(posedge clk);
      if (mdLeft > 0) mdLeft--;
      else if ((isMul() || isDivOp()) && !s) mdLeft = isDivOp() ? 32 : 5;
      if (s && stallCnt < 65535) stallCnt++;
      @(negedge clk);
   endtask

   task automatic idle();
      opcode = 0; funct = 0; rs = 0; rt = 0; rdIdex = 0; rdExmem = 0;
      memReadIdex = 0; regWriteIdex = 0; memReadExmem = 0; brTaken = 0;
   endtask

   initial begin
      idle();
      #2;
      check("rst.busy", mdBusy, 0);
      check("rst.cnt", stallCount, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      #1;
      check("rst.pc", pcWrite, 1);
      check("rst.ifid", ifidWrite, 1);
      check("rst.idex", idexFlush, 0);
      check("rst.iflush", ifidFlush, 0);
      step("idle");

      // Load-use: one stall cycle, then the bubble has cleared the dependency.
      memReadIdex = 1; rdIdex = 8; rt = 8;
      #1;
      check("lu.pc", pcWrite, 0);
      check("lu.idex", idexFlush, 1);
      step("lu");
      idle();
      #1;
      check("lu2.pc", pcWrite, 1);
      check("lu2.cnt", stallCount, 1);
      step("lu2");

      // Taken branch waiting on an ALU result must not flush until it proceeds.
      opcode = 6'h04; rs = 9; regWriteIdex = 1; rdIdex = 9; brTaken = 1;
      #1;
      check("br.stall", idexFlush, 1);
      check("br.flush", ifidFlush, 0);
      step("br");
      regWriteIdex = 0; rdIdex = 0;
      #1;
      check("br2.flush", ifidFlush, 1);
      step("br2");
      idle();

      // Register 0 never stalls.
      memReadIdex = 1; rdIdex = 0; rs = 0;
      #1;
      check("r0.pc", pcWrite, 1);
      step("r0");
      idle();

      // Branch-load on a BR1 branch through Rs, and BR1 ignores Rt.
      opcode = 6'h06; rs = 3; memReadExmem = 1; rdExmem = 3;
      #1;
      check("bl.stall", idexFlush, 1);
      step("bl");
      rs = 4; rt = 3;
      #1;
      check("bl1rt.stall", idexFlush, 0);
      step("bl1rt");
      idle();

      // Divide: busy for cycles 1..32, mflo held in ID proceeds at cycle 33.
      opcode = 6'h00; funct = 6'h1A;
      step("div0");
      funct = 6'h12;
      for (int c = 1; c <= 32; c++) begin
         #1;
         check("div.busy", mdBusy, 1);
         check("div.stall", idexFlush, 1);
         step("div");
      end
      #1;
      check("div33.busy", mdBusy, 0);
      check("div33.pc", pcWrite, 1);
      step("div33");
      idle();

      // Randomized mix with small register numbers so dependencies are frequent.
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 5))
            0: opcode = 6'h04;
            1: opcode = 6'h05;
            2: opcode = 6'h01 + 6'($urandom_range(0, 1)) * 6'd5;
            3: opcode = 6'h07;
            default: opcode = 6'h00;
         endcase
         case ($urandom_range(0, 6))
            0: funct = 6'h18;
            1: funct = 6'h19;
            2: funct = 6'h1A;
            3: funct = 6'h1B;
            4: funct = 6'h10;
            5: funct = 6'h12;
            default: funct = 6'h20;
         endcase
         rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
         rdIdex = 5'($urandom_range(0, 3)); rdExmem = 5'($urandom_range(0, 3));
         memReadIdex = ($urandom_range(0, 3) == 0);
         regWriteIdex = 1'($urandom);
         memReadExmem = 1'($urandom);
         brTaken = 1'($urandom);
         step("rnd");
      end
      idle();

      // Asynchronous reset in the middle of a multiply aborts it.
      while (mdLeft > 0) step("drain");
      opcode = 6'h00; funct = 6'h18;
      step("mul0");
      idle();
      step("mul1");
      #3;
      rst_n = 0;
      #1;
      check("arst.busy", mdBusy, 0);
      check("arst.cnt", stallCount, 0);
      mdLeft = 0; stallCnt = 0;
      #1;
      rst_n = 1;
      @(negedge clk);
      funct = 6'h10;
      #1;
      check("arst.mfhi", pcWrite, 1);
      step("arst");
      idle();

      // Saturation: hold a load-use stall until the counter pins at FFFF.
      memReadIdex = 1; rdIdex = 7; rs = 7;
      for (int i = 0; i < 65534; i++) @(posedge clk);
      stallCnt = 65534;
      @(negedge clk);
      check("sat.pre", stallCount, 16'hFFFE);
      step("sat1");
      step("sat2");
      step("sat3");
      check("sat.final", stallCount, 16'hFFFF);
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
